reset_pulse_gen: RTL and testbench

// - Generates a clean active-low reset pulse (rst_n_out) of guaranteed minimum width for a downstream reset_sync.
// - Pulse is issued once after own reset and on every request; completion is confirmed by the sync's valid.
// - Driver side of the reset_sync interface; removes the sub-width glitches a $width check flags.

---
 rtl/rpg_pkg.sv | 28 ++
 rtl/reset_pulse_gen.sv | 140 ++++++++++++++
 tb/tb_reset_pulse_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpg_pkg.sv
// Package for reset_pulse_gen: FSM state encoding and phase-counter width helper.
package rpg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    RELEASE  = 2'd2,
    COOLDOWN = 2'd3
  } rpg_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One phase counter is shared by ASSERT, RELEASE (timeout) and COOLDOWN,
  // so it must hold the largest terminal count of the three.
  function automatic int unsigned cnt_width(input int unsigned min_low,
                                            input int unsigned recover,
                                            input int unsigned timeout);
    return $clog2(max3(min_low, recover, timeout) + 1);
  endfunction

endpackage

// File: rtl/reset_pulse_gen.sv
// reset_pulse_gen: issues a fixed-width active-low reset pulse to a downstream
// reset_sync after own reset and on each request, and waits for the sync's valid.
// Optional feature macro: RPG_TIMEOUT_EN (RELEASE timeout with sticky err and retry).
module reset_pulse_gen
  import rpg_pkg::*;
#(
  parameter int unsigned MIN_LOW = 4,
  parameter int unsigned RECOVER = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             valid_in,
  output logic             rst_n_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int unsigned   CW       = cnt_width(MIN_LOW, RECOVER, TIMEOUT);
  localparam logic [CW-1:0] LOW_LAST = CW'(MIN_LOW - 1);
  localparam logic [CW-1:0] REC_LAST = (RECOVER == 0) ? '0 : CW'(RECOVER - 1);
`ifdef RPG_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
`endif

  rpg_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             rst_n_q;
  logic             busy_q;
`ifdef RPG_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  // Next-state, phase counter, pending request, pulse count and done/err strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    pulse_d   = pulse_q;
    done_d    = 1'b0;
`ifdef RPG_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req || pending_q) begin
          state_d   = ASSERT;
          cnt_d     = '0;
          pending_d = 1'b0;
          if (pulse_q != '1) pulse_d = pulse_q + CNT_W'(1);
        end
      end
      ASSERT: begin
        // Requests are ignored here: the pulse is never extended or restarted.
        if (cnt_q == LOW_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (req) pending_d = 1'b1;
        if (valid_in) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = (RECOVER == 0) ? IDLE : COOLDOWN;
        end
`ifdef RPG_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Retry pulse after a missing valid; not counted as a served request.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ASSERT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      COOLDOWN: begin
        if (req) pending_d = 1'b1;
        if (cnt_q == REC_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pulse_q   <= '0;
      done_q    <= 1'b0;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b1;
`ifdef RPG_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      rst_n_q   <= (state_d != ASSERT);
      busy_q    <= (state_d != IDLE);
`ifdef RPG_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_q;
`ifdef RPG_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed testbench for reset_pulse_gen (default parameters).
module tb_reset_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       valid_in;
  logic       rst_n_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] pulse_cnt;

  int checks = 0;
  int errors = 0;

  reset_pulse_gen #(
    .MIN_LOW(4),
    .RECOVER(2),
    .TIMEOUT(16),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .valid_in (valid_in),
    .rst_n_out(rst_n_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that enters ASSERT: expect exactly 4 low cycles, then high.
  task automatic check_pulse(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_low"}, {31'd0, rst_n_out}, 32'd0);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      step();
    end
    chk({tag, "_high"}, {31'd0, rst_n_out}, 32'd1);
  endtask

  // Called in RELEASE: valid for one cycle, done for one cycle, idle two cycles later.
  task automatic handshake(input string tag);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_cool"}, {31'd0, busy}, 32'd1);
    step();
    chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
    step();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    valid_in = 1'b0;

    // Power-on reset for 3 cycles
    repeat (3) step();
    chk("rst_rst_n", {31'd0, rst_n_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pcnt", {24'd0, pulse_cnt}, 32'd0);
    rst = 1'b0;
    check_pulse("poweron");
    chk("poweron_pcnt", {24'd0, pulse_cnt}, 32'd0);

    // Release handshake: valid rises 2 cycles after release
    step();
    chk("rel_wait_done", {31'd0, done}, 32'd0);
    chk("rel_wait_busy", {31'd0, busy}, 32'd1);
    handshake("hs1");

    // Single-cycle request in IDLE, valid_in held high during ASSERT (ignored)
    req = 1'b1;
    step();
    req      = 1'b0;
    valid_in = 1'b1;
    chk("req1_pcnt", {24'd0, pulse_cnt}, 32'd1);
    check_pulse("req1");
    // Still RELEASE with valid high: completes on the next edge
    step();
    valid_in = 1'b0;
    chk("req1_done", {31'd0, done}, 32'd1);
    // Request during COOLDOWN -> pending
    req = 1'b1;
    step();
    req = 1'b0;
    chk("cool_busy", {31'd0, busy}, 32'd1);
    step();
    chk("pend_idle_busy", {31'd0, busy}, 32'd0);
    step();
    chk("pend_pcnt", {24'd0, pulse_cnt}, 32'd2);
    check_pulse("pend");
    handshake("hs2");
    chk("hs2_pcnt", {24'd0, pulse_cnt}, 32'd2);

    // Request held through two ASSERT cycles: ignored, pulse not extended
    req = 1'b1;
    step();
    chk("req3_pcnt", {24'd0, pulse_cnt}, 32'd3);
    chk("req3_low0", {31'd0, rst_n_out}, 32'd0);
    step();
    req = 1'b0;
    chk("req3_low1", {31'd0, rst_n_out}, 32'd0);
    step();
    chk("req3_low2", {31'd0, rst_n_out}, 32'd0);
    step();
    chk("req3_low3", {31'd0, rst_n_out}, 32'd0);
    step();
    chk("req3_high", {31'd0, rst_n_out}, 32'd1);
    handshake("hs3");
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("idle_valid_done", {31'd0, done}, 32'd0);
    chk("idle_no_pend", {31'd0, busy}, 32'd0);
    chk("idle_pcnt", {24'd0, pulse_cnt}, 32'd3);

    // Mid-pulse reset at ASSERT cycle 2
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_low", {31'd0, rst_n_out}, 32'd0);
    chk("midrst_pcnt", {24'd0, pulse_cnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    check_pulse("midrst");

    // Reset in RELEASE with pending set and valid high: done suppressed, pending lost
    req = 1'b1;
    step();
    req      = 1'b0;
    rst      = 1'b1;
    valid_in = 1'b1;
    step();
    rst      = 1'b0;
    valid_in = 1'b0;
    chk("relrst_done", {31'd0, done}, 32'd0);
    check_pulse("relrst");
    handshake("hs4");
    step();
    chk("pend_lost_busy", {31'd0, busy}, 32'd0);
    chk("pend_lost_pcnt", {24'd0, pulse_cnt}, 32'd0);

`ifdef RPG_TIMEOUT_EN
    // Timeout: valid held low for 16 cycles in RELEASE from a fresh pulse
    req = 1'b1;
    step();
    req = 1'b0;
    check_pulse("to_pre");
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_err", {31'd0, err}, 32'd0);
      chk("to_wait_high", {31'd0, rst_n_out}, 32'd1);
      step();
    end
    chk("to_wait_last", {31'd0, rst_n_out}, 32'd1);
    step();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd0);
    chk("to_pcnt", {24'd0, pulse_cnt}, 32'd1);
    check_pulse("to_retry");
    handshake("hs_to");
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_err_clr", {31'd0, err}, 32'd0);
    check_pulse("to_post");
    handshake("hs_to2");
`else
    chk("err_tied", {31'd0, err}, 32'd0);
`endif

    // Saturation of pulse_cnt at 255
    for (int n = 0; n < 256; n++) begin
      req = 1'b1;
      step();
      req = 1'b0;
      repeat (4) step();
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      step();
      if (n == 254) chk("sat_255", {24'd0, pulse_cnt}, 32'd255);
    end
    chk("sat_hold", {24'd0, pulse_cnt}, 32'd255);
    chk("sat_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
